tm_tape_pred_multi: RTL and testbench

Multi-tape, parametrised tape-direction predictor for the Turing-machine core. There is one independent predictor lane per tape head. Each lane keeps a shift history of head moves and a table of saturating counters indexed by the most recent moves. A counter is trained when a run of identical moves completes. New over the single-tape predictor: configurable counter width and run length, per-lane warm-up gating, per-lane flush, and saturating hit/miss statistics shared across lanes.

---
 rtl/tm_pred_pkg.sv | 35 +++
 rtl/tm_tape_pred_lane.sv | 97 +++++++++
 rtl/tm_tape_pred_multi.sv | 83 ++++++++
 tb/tb_tm_tape_pred_multi.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/tm_pred_pkg.sv
// Shared sizing helpers and event types for the multi-tape direction predictor.
package tm_pred_pkg;

    localparam int unsigned MAX_TAPES = 8;
    localparam int unsigned POP_W     = 4;

    // Per-lane scoring strobes raised on a training event.
    typedef struct packed {
        logic hit;
        logic miss;
    } lane_evt_t;

    function automatic int unsigned hw_f(input int unsigned hist_bits, input int unsigned run_len);
        return hist_bits + run_len;
    endfunction

    function automatic int unsigned cmax_f(input int unsigned cnt_bits);
        return (32'd1 << cnt_bits) - 32'd1;
    endfunction

    // Weakly-left starting point, one below the midpoint.
    function automatic int unsigned cinit_f(input int unsigned cnt_bits);
        return (32'd1 << (cnt_bits - 32'd1)) - 32'd1;
    endfunction

    function automatic logic [POP_W-1:0] popcount(input logic [MAX_TAPES-1:0] v);
        logic [POP_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(MAX_TAPES); i++) begin
            cnt = cnt + POP_W'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/tm_tape_pred_lane.sv
// One tape head's predictor: move history, saturating counter table,
// zero-latency prediction and hit/miss strobes for the shared statistics.
module tm_tape_pred_lane
    import tm_pred_pkg::*;
#(
    parameter int unsigned HIST_BITS = 3,
    parameter int unsigned RUN_LEN   = 3,
    parameter int unsigned CNT_BITS  = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      move,
    input  logic      dir,
    input  logic      flush,
    output logic      pred_r_c,
    output logic      pred_l_c,
    output logic      pred_valid,
    output lane_evt_t evt_c
);

    localparam int unsigned HW      = hw_f(HIST_BITS, RUN_LEN);
    localparam int unsigned DEPTH   = 2 ** HIST_BITS;
    localparam int unsigned FW      = $clog2(HW + 1);
    localparam int unsigned CMAX_V  = cmax_f(CNT_BITS);
    localparam int unsigned CINIT_V = cinit_f(CNT_BITS);

    localparam logic [CNT_BITS-1:0] CMAX  = CNT_BITS'(CMAX_V);
    localparam logic [CNT_BITS-1:0] CINIT = CNT_BITS'(CINIT_V);
    localparam logic [FW-1:0]       FULL  = FW'(HW);
    localparam logic [FW-1:0]       NEAR  = FW'(HW - 1);

    logic [HW-1:0]        hist;
    logic [FW-1:0]        fill;
    logic [CNT_BITS-1:0]  tbl [DEPTH];

    logic [HIST_BITS-1:0] recent;
    logic [HIST_BITS-1:0] past;
    logic [RUN_LEN-1:0]   outcome;
    logic                 run_r;
    logic                 run_l;
    logic                 adv;
    logic                 train;
    logic [CNT_BITS-1:0]  cur;
    logic [CNT_BITS-1:0]  pred_val;

    assign recent   = hist[HIST_BITS-1:0];
    assign past     = hist[HW-1:RUN_LEN];
    assign outcome  = hist[RUN_LEN-1:0];
    assign run_r    = &outcome;
    assign run_l    = ~|outcome;
    assign adv      = move & ~flush;
    assign train    = adv & pred_valid & (run_r | run_l);
    assign cur      = tbl[past];
    assign pred_val = tbl[recent];

    assign pred_r_c = pred_valid & (pred_val == CMAX);
    assign pred_l_c = pred_valid & (pred_val == '0);

    // Scoring looks at the counter before this edge's training update.
    assign evt_c.hit  = train & ((run_r & (cur == CMAX)) | (run_l & (cur == '0)));
    assign evt_c.miss = train & ((run_r & (cur == '0))   | (run_l & (cur == CMAX)));

    // History, warm-up fill and validity; flush drops a simultaneous move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist       <= '1;
            fill       <= '0;
            pred_valid <= 1'b0;
        end else if (flush) begin
            hist       <= '1;
            fill       <= '0;
            pred_valid <= 1'b0;
        end else if (move) begin
            hist       <= {hist[HW-2:0], dir};
            pred_valid <= (fill >= NEAR);
            if (fill != FULL) begin
                fill <= fill + FW'(1);
            end
        end
    end

    // Counter table survives flush; only a completed run trains it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                tbl[i] <= CINIT;
            end
        end else if (train) begin
            if (run_r && (cur != CMAX)) begin
                tbl[past] <= cur + CNT_BITS'(1);
            end else if (run_l && (cur != '0)) begin
                tbl[past] <= cur - CNT_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/tm_tape_pred_multi.sv
// Multi-tape direction predictor: independent lanes plus saturating
// hit/miss statistics aggregated across all lanes.
module tm_tape_pred_multi
    import tm_pred_pkg::*;
#(
    parameter int unsigned TAPES     = 2,
    parameter int unsigned HIST_BITS = 3,
    parameter int unsigned RUN_LEN   = 3,
    parameter int unsigned CNT_BITS  = 2,
    parameter int unsigned STAT_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [TAPES-1:0]     move_i,
    input  logic [TAPES-1:0]     dir_i,
    input  logic [TAPES-1:0]     flush_i,
    input  logic                 stat_clr_i,
    output logic [TAPES-1:0]     pred_r_o,
    output logic [TAPES-1:0]     pred_l_o,
    output logic [TAPES-1:0]     pred_valid_o,
    output logic [STAT_BITS-1:0] hit_cnt_o,
    output logic [STAT_BITS-1:0] miss_cnt_o
);

    localparam int unsigned SW = STAT_BITS + POP_W;
    localparam logic [SW-1:0] SMAX = SW'({STAT_BITS{1'b1}});

    lane_evt_t            evt [TAPES];
    logic [MAX_TAPES-1:0] hit_vec;
    logic [MAX_TAPES-1:0] miss_vec;
    logic [POP_W-1:0]     hit_pop;
    logic [POP_W-1:0]     miss_pop;
    logic [SW-1:0]        hit_sum;
    logic [SW-1:0]        miss_sum;

    for (genvar g = 0; g < int'(TAPES); g++) begin : g_lane
        tm_tape_pred_lane #(
            .HIST_BITS (HIST_BITS),
            .RUN_LEN   (RUN_LEN),
            .CNT_BITS  (CNT_BITS)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .move       (move_i[g]),
            .dir        (dir_i[g]),
            .flush      (flush_i[g]),
            .pred_r_c   (pred_r_o[g]),
            .pred_l_c   (pred_l_o[g]),
            .pred_valid (pred_valid_o[g]),
            .evt_c      (evt[g])
        );
    end

    // Gather lane strobes into fixed-width vectors for the popcount.
    always_comb begin
        hit_vec  = '0;
        miss_vec = '0;
        for (int i = 0; i < int'(TAPES); i++) begin
            hit_vec[i]  = evt[i].hit;
            miss_vec[i] = evt[i].miss;
        end
    end

    assign hit_pop  = popcount(hit_vec);
    assign miss_pop = popcount(miss_vec);
    assign hit_sum  = SW'(hit_cnt_o) + SW'(hit_pop);
    assign miss_sum = SW'(miss_cnt_o) + SW'(miss_pop);

    // Saturating statistics; a clear overrides same-cycle events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else if (stat_clr_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            hit_cnt_o  <= (hit_sum > SMAX)  ? '1 : STAT_BITS'(hit_sum);
            miss_cnt_o <= (miss_sum > SMAX) ? '1 : STAT_BITS'(miss_sum);
        end
    end

endmodule

// File: tb/tb_tm_tape_pred_multi.sv
// Directed bench for tm_tape_pred_multi: default, narrow-stat and
// wide-counter/short-run instances share one clock and reset.
module tb_tm_tape_pred_multi;

    logic clk;
    logic rst_n;

    logic [1:0] mv_a, dir_a, fl_a, pr_a, pl_a, pv_a;
    logic       clr_a;
    logic [7:0] hit_a, miss_a;

    logic [1:0] mv_b, dir_b, fl_b, pr_b, pl_b, pv_b;
    logic       clr_b;
    logic [3:0] hit_b, miss_b;

    logic [1:0] mv_c, dir_c, fl_c, pr_c, pl_c, pv_c;
    logic       clr_c;
    logic [7:0] hit_c, miss_c;

    int n_cmp;
    int n_err;

    tm_tape_pred_multi u_dut_a (
        .clk(clk), .rst_n(rst_n), .move_i(mv_a), .dir_i(dir_a), .flush_i(fl_a),
        .stat_clr_i(clr_a), .pred_r_o(pr_a), .pred_l_o(pl_a), .pred_valid_o(pv_a),
        .hit_cnt_o(hit_a), .miss_cnt_o(miss_a)
    );

    tm_tape_pred_multi #(.STAT_BITS(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .move_i(mv_b), .dir_i(dir_b), .flush_i(fl_b),
        .stat_clr_i(clr_b), .pred_r_o(pr_b), .pred_l_o(pl_b), .pred_valid_o(pv_b),
        .hit_cnt_o(hit_b), .miss_cnt_o(miss_b)
    );

    tm_tape_pred_multi #(.CNT_BITS(3), .RUN_LEN(2)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .move_i(mv_c), .dir_i(dir_c), .flush_i(fl_c),
        .stat_clr_i(clr_c), .pred_r_o(pr_c), .pred_l_o(pl_c), .pred_valid_o(pv_c),
        .hit_cnt_o(hit_c), .miss_cnt_o(miss_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        mv_a = '0; dir_a = '0; fl_a = '0; clr_a = 1'b0;
        mv_b = '0; dir_b = '0; fl_b = '0; clr_b = 1'b0;
        mv_c = '0; dir_c = '0; fl_c = '0; clr_c = 1'b0;
    endtask

    // One clock edge with the currently driven inputs, then return to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid_a", 32'(pv_a), 0);
        check("async_rst_hit_a", 32'(hit_a), 0);
        #1 rst_n = 1'b1;
    endtask

    task automatic move_a(input logic [1:0] lanes, input logic [1:0] d);
        mv_a = lanes; dir_a = d; tick();
    endtask

    task automatic move_c(input logic d);
        mv_c = 2'b01; dir_c = {1'b0, d}; tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle_inputs();
        #12 rst_n = 1'b1;
        #1;

        check("rst_valid", 32'(pv_a), 0);
        check("rst_pred_r", 32'(pr_a), 0);
        check("rst_pred_l", 32'(pl_a), 0);
        check("rst_hit", 32'(hit_a), 0);
        check("rst_miss", 32'(miss_a), 0);

        // Warm-up then saturation to the right on lane 0.
        for (int k = 1; k <= 5; k++) begin
            move_a(2'b01, 2'b01);
            check("warm_valid", 32'(pv_a), 0);
        end
        move_a(2'b01, 2'b01);
        check("m6_valid", 32'(pv_a), 2'b01);
        check("m6_pred_r", 32'(pr_a), 0);
        check("m6_pred_l", 32'(pl_a), 0);
        move_a(2'b01, 2'b01);
        check("m7_pred_r", 32'(pr_a), 0);
        move_a(2'b01, 2'b01);
        check("m8_pred_r", 32'(pr_a), 2'b01);
        check("m8_pred_l", 32'(pl_a), 0);
        check("m8_hit", 32'(hit_a), 0);
        for (int k = 9; k <= 12; k++) begin
            move_a(2'b01, 2'b01);
            check("sat_hit", 32'(hit_a), 32'(k - 8));
            check("lane1_valid", 32'(pv_a), 2'b01);
            check("lane1_pred", 32'({pr_a[1], pl_a[1]}), 0);
        end
        check("sat_miss", 32'(miss_a), 0);

        // Both lanes run left; simultaneous hits then a miss on lane 0.
        do_reset();
        for (int k = 1; k <= 6; k++) move_a(2'b11, 2'b00);
        check("l6_valid", 32'(pv_a), 2'b11);
        check("l6_pred_l", 32'(pl_a), 0);
        move_a(2'b11, 2'b00);
        check("l7_pred_l", 32'(pl_a), 2'b11);
        check("l7_hit", 32'(hit_a), 0);
        move_a(2'b11, 2'b00);
        check("l8_hit", 32'(hit_a), 2);
        move_a(2'b11, 2'b00);
        check("l9_hit", 32'(hit_a), 4);
        move_a(2'b01, 2'b01);
        check("r1_hit", 32'(hit_a), 5);
        move_a(2'b01, 2'b01);
        move_a(2'b01, 2'b01);
        check("r3_miss", 32'(miss_a), 0);
        move_a(2'b01, 2'b01);
        check("r4_miss", 32'(miss_a), 1);
        check("r4_hit", 32'(hit_a), 5);
        check("r4_pred_l", 32'(pl_a), 2'b10);

        // Flush keeps the table; re-warming predicts at once.
        do_reset();
        for (int k = 1; k <= 8; k++) move_a(2'b01, 2'b01);
        check("fl_pre_pred_r", 32'(pr_a), 2'b01);
        mv_a = 2'b01; fl_a = 2'b01; dir_a = 2'b00; tick();
        check("fl_valid", 32'(pv_a), 0);
        check("fl_pred_r", 32'(pr_a), 0);
        check("fl_hit", 32'(hit_a), 0);
        for (int k = 1; k <= 5; k++) move_a(2'b01, 2'b01);
        check("fl_rewarm_valid", 32'(pv_a), 0);
        move_a(2'b01, 2'b01);
        check("fl_re_valid", 32'(pv_a), 2'b01);
        check("fl_re_pred_r", 32'(pr_a), 2'b01);
        check("fl_re_hit", 32'(hit_a), 0);

        // Narrow statistics: saturation at 15 and clear priority.
        do_reset();
        for (int k = 1; k <= 15; k++) begin
            mv_b = 2'b11; dir_b = 2'b11; tick();
            if (k == 8) check("b_m8_hit", 32'(hit_b), 0);
            if (k == 12) check("b_m12_hit", 32'(hit_b), 8);
        end
        check("b_m15_hit", 32'(hit_b), 14);
        mv_b = 2'b11; dir_b = 2'b11; tick();
        check("b_sat_hit", 32'(hit_b), 15);
        mv_b = 2'b11; dir_b = 2'b11; tick();
        check("b_hold_hit", 32'(hit_b), 15);
        mv_b = 2'b11; dir_b = 2'b11; clr_b = 1'b1; tick();
        check("b_clr_hit", 32'(hit_b), 0);
        mv_b = 2'b11; dir_b = 2'b11; tick();
        check("b_post_clr_hit", 32'(hit_b), 2);
        check("b_miss", 32'(miss_b), 0);

        // Wide counters, short runs: alternation never trains.
        do_reset();
        move_c(1'b1); move_c(1'b0); move_c(1'b1); move_c(1'b0);
        check("c_m4_valid", 32'(pv_c), 0);
        move_c(1'b1);
        check("c_m5_valid", 32'(pv_c), 2'b01);
        move_c(1'b0); move_c(1'b1); move_c(1'b0); move_c(1'b1);
        check("c_alt_pred", 32'({pr_c[0], pl_c[0]}), 0);
        check("c_alt_hit", 32'(hit_c), 0);
        check("c_alt_miss", 32'(miss_c), 0);
        for (int k = 1; k <= 7; k++) begin
            move_c(1'b1);
            check("c_climb_pred_r", 32'(pr_c), 0);
        end
        move_c(1'b1);
        check("c_top_pred_r", 32'(pr_c), 2'b01);
        check("c_top_hit", 32'(hit_c), 0);
        move_c(1'b1);
        check("c_hit", 32'(hit_c), 1);
        check("c_miss", 32'(miss_c), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
